// File: rtl/dac_control.sv
// dac_control: triggered burst playback from a valid/ready sample stream onto a
// 12-bit parallel DAC clocked at Clk/CLK_DIV, with a static idle code between bursts.
module dac_control #(
  parameter int CLK_DIV = 4
) (
  input  logic        Clk,
  input  logic        reset_n,
  input  logic        Trigger,
  input  logic        StartGen,
  input  logic [3:0]  DacStartDelay,
  input  logic [7:0]  DacDataNumber,
  input  logic [11:0] IdleCode,
  input  logic [11:0] SampleData,
  input  logic        SampleValid,
  output logic        SampleReady,
  output logic        DAC_CLK,
  output logic [11:0] DAC_DATA,
  output logic        Busy,
  output logic        Done,
  output logic        Underrun
);
  localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] HALF = PW'(CLK_DIV / 2);

  typedef enum logic [1:0] {IDLE, DELAY, PLAY, DONE} state_t;
  state_t state, stateNext;

  logic [PW-1:0] phase, phaseNext;
  logic          trigMeta, trigSync, trigDly;
  logic [3:0]    delayCount, delayLat;
  logic [7:0]    sampleCount, numberLat;
  logic          phaseEnd, accept;

  assign phaseEnd    = phase == LAST;
  assign phaseNext   = phaseEnd ? '0 : phase + 1'b1;
  assign accept      = state == IDLE && trigSync && !trigDly && StartGen;
  // Ready is withheld once StartGen drops so an aborted burst takes no further samples
  assign SampleReady = state == PLAY && phase == '0 && StartGen;
  assign Busy        = state != IDLE;
  assign Done        = state == DONE && phaseEnd;

  always_ff @(posedge Clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else          state <= stateNext;

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    stateNext = accept ? DELAY : IDLE;
      DELAY:   stateNext = !StartGen ? DONE :
                           (phaseEnd && delayCount >= delayLat) ? (numberLat == 8'd0 ? DONE : PLAY) : DELAY;
      PLAY:    stateNext = (!StartGen || (SampleReady && sampleCount + 8'd1 == numberLat)) ? DONE : PLAY;
      DONE:    stateNext = phaseEnd ? IDLE : DONE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge reset_n)
    if (!reset_n) begin
      phase       <= '0;
      DAC_CLK     <= 1'b0;
      DAC_DATA    <= 12'h000;
      Underrun    <= 1'b0;
      trigMeta    <= 1'b0;
      trigSync    <= 1'b0;
      trigDly     <= 1'b0;
      delayCount  <= '0;
      delayLat    <= '0;
      sampleCount <= '0;
      numberLat   <= '0;
    end else begin
      phase    <= phaseNext;
      DAC_CLK  <= phaseNext >= HALF;
      trigMeta <= Trigger;
      trigSync <= trigMeta;
      trigDly  <= trigSync;
      if (accept) begin
        delayLat    <= DacStartDelay;
        numberLat   <= DacDataNumber;
        delayCount  <= '0;
        sampleCount <= '0;
        Underrun    <= 1'b0;
      end
      if (state == DELAY && phaseEnd && delayCount < delayLat)
        delayCount <= delayCount + 4'd1;
      // A missing sample still consumes its slot; the DAC repeats the last code
      if (SampleReady) begin
        sampleCount <= sampleCount + 8'd1;
        if (SampleValid) DAC_DATA <= SampleData;
        else             Underrun <= 1'b1;
      end
      if (state == IDLE && phase == '0)
        DAC_DATA <= IdleCode;
    end
endmodule

// File: tb/tb_dac_control.sv
// tb_dac_control: table-driven burst runs with a DAC-code scoreboard checked on
// each DAC_CLK rising edge, plus hand-written reset and power-on sequences.
module tb_dac_control;
  localparam int CLK_DIV = 4;
  localparam logic [11:0] IDLE_CODE = 12'h800;

  logic        Clk = 1'b0, reset_n = 1'b0, Trigger = 1'b0, StartGen = 1'b0, SampleValid = 1'b0;
  logic [3:0]  DacStartDelay = '0;
  logic [7:0]  DacDataNumber = '0;
  logic [11:0] IdleCode = IDLE_CODE, SampleData = '0;
  logic        SampleReady, DAC_CLK, Busy, Done, Underrun;
  logic [11:0] DAC_DATA;

  int nAssert = 0, nFail = 0, tphase = 0, cyc = 0;
  logic [11:0] q[$];

  typedef struct {
    logic [3:0]  delay;
    logic [7:0]  n;
    logic [15:0] mask;
    int          abortAt;
    bit          retrig;
    logic [7:0]  tag;
    int          expSlots;
    bit          expUnder;
  } vec_t;
  vec_t vecs[7];

  dac_control #(.CLK_DIV(CLK_DIV)) dut (
    .Clk(Clk), .reset_n(reset_n), .Trigger(Trigger), .StartGen(StartGen),
    .DacStartDelay(DacStartDelay), .DacDataNumber(DacDataNumber), .IdleCode(IdleCode),
    .SampleData(SampleData), .SampleValid(SampleValid), .SampleReady(SampleReady),
    .DAC_CLK(DAC_CLK), .DAC_DATA(DAC_DATA), .Busy(Busy), .Done(Done), .Underrun(Underrun)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nAssert++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [11:0] sdata(input int k, input logic [7:0] tag);
    return 12'((k + 1) * 256) | {4'h0, tag};
  endfunction

  // Advance one Clk from a negedge to the next; bench tracks the free-running phase itself
  task automatic step();
    logic pc;
    logic [11:0] e;
    pc = DAC_CLK;
    @(posedge Clk);
    tphase = (tphase + 1) % CLK_DIV;
    cyc++;
    @(negedge Clk);
    check("dac_clk", 32'(DAC_CLK), 32'(tphase >= CLK_DIV / 2));
    if (DAC_CLK && !pc && q.size() > 0) begin
      e = q.pop_front();
      check("dac_data", 32'(DAC_DATA), 32'(e));
    end
  endtask

  task automatic run(input vec_t v);
    int A, pA, firstExp, lastSlot, slots, dones, doneAt;
    logic [11:0] prev, e;
    bit abortPend;
    slots = 0; dones = 0; doneAt = 0; abortPend = 1'b0; prev = IDLE_CODE;
    DacStartDelay = v.delay; DacDataNumber = v.n; StartGen = 1'b1; Trigger = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      check("accept_latency", 32'(Busy), 32'(i == 3));
    end
    A = cyc; pA = tphase;
    check("underrun_cleared", 32'(Underrun), 32'(0));
    Trigger = 1'b0; DacStartDelay = 4'hF; DacDataNumber = 8'hFF;
    firstExp = A + (CLK_DIV - 1 - pA) + CLK_DIV * int'(v.delay) + 1;
    lastSlot = firstExp;
    for (int i = 0; i < 600; i++) begin
      if (SampleReady) begin
        check("slot_time", 32'(cyc), 32'(firstExp + slots * CLK_DIV));
        SampleValid = v.mask[slots % 16];
        SampleData = sdata(slots, v.tag);
        e = SampleValid ? SampleData : prev;
        prev = e;
        q.push_back(e);
        if (v.retrig && slots == 1) Trigger = 1'b1;
        slots++;
        lastSlot = cyc;
        abortPend = slots == v.abortAt;
      end else begin
        SampleValid = 1'b0;
        SampleData = 12'hABC;
        if (abortPend) begin
          StartGen = 1'b0;
          abortPend = 1'b0;
        end
      end
      if (slots == 0) check("idle_code_hold", 32'(DAC_DATA), 32'(IDLE_CODE));
      if (Done) begin
        dones++;
        doneAt = cyc;
        check("busy_at_done", 32'(Busy), 32'(1));
      end
      if (dones > 0 && cyc == doneAt + 1) check("busy_after_done", 32'(Busy), 32'(0));
      if (dones > 0 && cyc >= doneAt + 12) break;
      step();
    end
    check("slot_count", 32'(slots), 32'(v.expSlots));
    check("done_pulses", 32'(dones), 32'(1));
    check("done_time", 32'(doneAt), 32'(lastSlot + CLK_DIV - 1));
    check("scoreboard_drained", 32'(q.size()), 32'(0));
    check("underrun", 32'(Underrun), 32'(v.expUnder));
    check("idle_return", 32'(DAC_DATA), 32'(IDLE_CODE));
    check("no_restart", 32'(Busy), 32'(0));
    q.delete();
    Trigger = 1'b0; StartGen = 1'b1;
    repeat (3) step();
  endtask

  initial begin
    //          delay  n      mask       abort retrig tag    slots under
    vecs[0] = '{4'd0, 8'd3,  16'hFFFF, 0,    1'b0,  8'h00, 3,    1'b0};
    vecs[1] = '{4'd5, 8'd1,  16'hFFFF, 0,    1'b0,  8'h15, 1,    1'b0};
    vecs[2] = '{4'd0, 8'd0,  16'hFFFF, 0,    1'b0,  8'h20, 0,    1'b0};
    vecs[3] = '{4'd2, 8'd4,  16'hFFFD, 0,    1'b1,  8'h34, 4,    1'b1};
    vecs[4] = '{4'd1, 8'd10, 16'hFFFF, 2,    1'b0,  8'h4A, 2,    1'b0};
    vecs[5] = '{4'd3, 8'd2,  16'hFFFF, 0,    1'b0,  8'h52, 2,    1'b0};
    vecs[6] = '{4'd1, 8'd3,  16'hFFFF, 0,    1'b0,  8'h63, 3,    1'b0};

    #1;
    check("por_dac_data", 32'(DAC_DATA), 32'(0));
    check("por_dac_clk", 32'(DAC_CLK), 32'(0));
    check("por_busy", 32'(Busy), 32'(0));
    check("por_done", 32'(Done), 32'(0));
    check("por_underrun", 32'(Underrun), 32'(0));
    check("por_ready", 32'(SampleReady), 32'(0));
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    reset_n = 1'b1; tphase = 0; cyc = 0;
    step();
    check("idle_after_por", 32'(DAC_DATA), 32'(IDLE_CODE));

    for (int v = 0; v < 6; v++) run(vecs[v]);

    // Reset in the middle of playback, with Underrun already set and DAC_CLK high
    DacStartDelay = 4'd0; DacDataNumber = 8'd8; StartGen = 1'b1; Trigger = 1'b1;
    repeat (3) step();
    Trigger = 1'b0;
    for (int i = 0; i < 40 && !SampleReady; i++) step();
    check("rst_seq_slot", 32'(SampleReady), 32'(1));
    SampleValid = 1'b0;
    step();
    check("rst_seq_underrun", 32'(Underrun), 32'(1));
    check("rst_seq_busy", 32'(Busy), 32'(1));
    step();
    reset_n = 1'b0;
    #1;
    check("rst_dac_data", 32'(DAC_DATA), 32'(0));
    check("rst_dac_clk", 32'(DAC_CLK), 32'(0));
    check("rst_busy", 32'(Busy), 32'(0));
    check("rst_done", 32'(Done), 32'(0));
    check("rst_underrun", 32'(Underrun), 32'(0));
    check("rst_ready", 32'(SampleReady), 32'(0));
    @(posedge Clk);
    @(negedge Clk);
    reset_n = 1'b1; tphase = 0;
    step();
    check("idle_after_rst", 32'(DAC_DATA), 32'(IDLE_CODE));
    run(vecs[6]);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end
endmodule
